// File: rtl/ahb_rr_arbiter.sv
// ============================================================================
//  Module      : ahb_rr_arbiter
//  Description : Parametrised AHB bus arbiter with fixed-priority or
//                round-robin selection, locked transfers and a burst cap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MASTER_BITS = $clog2(NUM_MASTERS),
   parameter int PRIO_MODE   = 1,
   parameter int DEF_MASTER  = 0,
   parameter int MAX_BEATS   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [1:0]             htrans,
   input  logic                   hready,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MASTER_BITS-1:0] hmaster,
   output logic [MASTER_BITS-1:0] hmaster_data,
   output logic                   hmastlock
);

   localparam int                   c_cnt_w   = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [MASTER_BITS-1:0] c_def_idx = MASTER_BITS'(DEF_MASTER);
   localparam logic [MASTER_BITS-1:0] c_last_idx = MASTER_BITS'(NUM_MASTERS - 1);
   localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(MAX_BEATS);

   logic [MASTER_BITS-1:0]   r_owner;
   logic [MASTER_BITS-1:0]   r_rr_ptr;
   logic [c_cnt_w-1:0]       r_beat_cnt;

   logic [NUM_MASTERS-1:0]   w_mask;
   logic [2*NUM_MASTERS-1:0] w_mask_dbl;
   logic [MASTER_BITS-1:0]   w_arb_idx;
   logic [MASTER_BITS-1:0]   w_next;
   logic [MASTER_BITS-1:0]   w_next_ptr;
   logic                     w_cap_ok;
   logic                     w_others;
   logic                     w_hold;
   logic                     w_change;
   logic                     w_unused;

   assign w_unused = htrans[0];

   // Grant is kept as an owner index so exactly one hgrant bit is ever high.
   always_comb begin
      hgrant          = '0;
      hgrant[r_owner] = 1'b1;
   end

   generate
      if (MAX_BEATS == 0) begin : g_no_cap
         assign w_cap_ok = 1'b1;
      end else begin : g_cap
         assign w_cap_ok = (r_beat_cnt < c_cnt_w'(MAX_BEATS - 1));
      end
   endgenerate

   assign w_mask     = hbusreq & ~hgrant;
   assign w_mask_dbl = {w_mask, w_mask};
   assign w_others   = |w_mask;
   assign w_hold     = hlock[r_owner] | hmastlock |
                       (hbusreq[r_owner] & (w_cap_ok | ~w_others));

   // Descending scans so the last hit is the highest-priority candidate.
   always_comb begin
      w_arb_idx = c_def_idx;
      if (PRIO_MODE == 0) begin
         for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_mask[i]) w_arb_idx = MASTER_BITS'(i);
         end
      end else begin
         for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_mask_dbl[int'(r_rr_ptr) + k])
               w_arb_idx = MASTER_BITS'((int'(r_rr_ptr) + k) % NUM_MASTERS);
         end
      end
   end

   assign w_next     = w_hold ? r_owner : w_arb_idx;
   assign w_change   = (w_next != r_owner);
   assign w_next_ptr = (w_next == c_last_idx) ? '0 : w_next + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= c_def_idx;
         r_rr_ptr     <= c_def_idx;
         r_beat_cnt   <= '0;
         hmaster      <= c_def_idx;
         hmaster_data <= c_def_idx;
         hmastlock    <= 1'b0;
      end else if (hready) begin
         r_owner      <= w_next;
         hmaster      <= r_owner;
         hmaster_data <= hmaster;
         hmastlock    <= hlock[r_owner];
         if (w_change) begin
            r_beat_cnt <= '0;
            r_rr_ptr   <= w_next_ptr;
         end else if (htrans[1] && (r_beat_cnt < c_cnt_max)) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
// ============================================================================
//  Module      : tb_ahb_rr_arbiter
//  Description : Scoreboard bench for ahb_rr_arbiter (round-robin and fixed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_rr_arbiter;

   localparam logic [1:0] c_idle = 2'b00;
   localparam logic [1:0] c_ns   = 2'b10;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] hbusreq, hlock;
   logic [1:0] htrans;
   logic       hready;

   logic [3:0] rr_gnt, fp_gnt;
   logic [1:0] rr_mst, rr_md, fp_mst, fp_md;
   logic       rr_ml, fp_ml;

   always #5 clk = ~clk;

   ahb_rr_arbiter #(.NUM_MASTERS(4), .PRIO_MODE(1), .DEF_MASTER(0), .MAX_BEATS(8)) dut (
      .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
      .hready(hready), .hgrant(rr_gnt), .hmaster(rr_mst), .hmaster_data(rr_md),
      .hmastlock(rr_ml));

   ahb_rr_arbiter #(.NUM_MASTERS(4), .PRIO_MODE(0), .DEF_MASTER(0), .MAX_BEATS(8)) dut_fp (
      .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
      .hready(hready), .hgrant(fp_gnt), .hmaster(fp_mst), .hmaster_data(fp_md),
      .hmastlock(fp_ml));

   typedef struct {
      int         tag;
      bit         fp;
      logic [3:0] g;
      logic [1:0] m;
      logic [1:0] d;
      logic       l;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   tag   = 0;
   int   e_g, e_m, e_d;
   logic e_l;

   task automatic cmp(input string what, input int tg, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (test %0d) t=%0t: got %b want %b", what, tg, $time, act, exp);
      end
   endtask

   task automatic check(input exp_t e);
      if (e.fp) begin
         cmp("hgrant",       e.tag, fp_gnt,          e.g);
         cmp("hmaster",      e.tag, {2'b00, fp_mst}, {2'b00, e.m});
         cmp("hmaster_data", e.tag, {2'b00, fp_md},  {2'b00, e.d});
         cmp("hmastlock",    e.tag, {3'b000, fp_ml}, {3'b000, e.l});
      end else begin
         cmp("hgrant",       e.tag, rr_gnt,          e.g);
         cmp("hmaster",      e.tag, {2'b00, rr_mst}, {2'b00, e.m});
         cmp("hmaster_data", e.tag, {2'b00, rr_md},  {2'b00, e.d});
         cmp("hmastlock",    e.tag, {3'b000, rr_ml}, {3'b000, e.l});
      end
   endtask

   // Drive one cycle of inputs; gnt is the hand-derived owner after the next edge.
   task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic rdy, input int gnt, input bit fp);
      exp_t e;
      @(negedge clk);
      hbusreq = req;
      hlock   = lk;
      htrans  = tr;
      hready  = rdy;
      if (rdy) begin
         e_l = lk[e_g];
         e_d = e_m;
         e_m = e_g;
         e_g = gnt;
      end
      e.tag = tag;
      e.fp  = fp;
      e.g   = 4'b0001 << e_g;
      e.m   = 2'(e_m);
      e.d   = 2'(e_d);
      e.l   = e_l;
      sb.push_back(e);
   endtask

   // Asynchronous reset asserted mid-cycle and checked before any clock edge.
   task automatic do_reset();
      exp_t r;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      r.tag = tag; r.g = 4'b0001; r.m = 2'd0; r.d = 2'd0; r.l = 1'b0;
      r.fp = 1'b0; check(r);
      r.fp = 1'b1; check(r);
      @(negedge clk);
      hbusreq = '0; hlock = '0; htrans = c_idle; hready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      e_g = 0; e_m = 0; e_d = 0; e_l = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e);
         end
      end
   end

   initial begin
      logic [3:0] req;
      rst = 1'b1; hbusreq = '0; hlock = '0; htrans = c_idle; hready = 1'b1;
      e_g = 0; e_m = 0; e_d = 0; e_l = 1'b0;

      // 1: idle after reset stays on the default master
      tag = 1;
      do_reset();
      repeat (10) step(4'b0000, 4'b0000, c_idle, 1'b1, 0, 1'b0);

      // 2: round-robin rotation, 8 beats per owner
      tag = 2;
      do_reset();
      for (int k = 1; k <= 36; k++) step(4'b1111, 4'b0000, c_ns, 1'b1, (k / 8) % 4, 1'b0);

      // 3: fixed priority with cap hand-over and return
      tag = 3;
      do_reset();
      for (int k = 1; k <= 19; k++) begin
         req = (k >= 10 && k <= 12) ? 4'b0100 : 4'b0110;
         step(req, 4'b0000, c_ns, 1'b1, (k <= 8) ? 1 : ((k <= 16) ? 2 : 1), 1'b1);
      end

      // 4: locked master 2 ignores the cap, held one cycle after unlock
      tag = 4;
      do_reset();
      step(4'b0100, 4'b0100, c_ns, 1'b1, 2, 1'b0);
      for (int k = 2; k <= 21; k++) step(4'b1111, 4'b0100, c_ns, 1'b1, 2, 1'b0);
      step(4'b1111, 4'b0000, c_ns, 1'b1, 2, 1'b0);
      step(4'b1111, 4'b0000, c_ns, 1'b1, 3, 1'b0);
      step(4'b1111, 4'b0000, c_ns, 1'b1, 3, 1'b0);

      // 5: hready low freezes grant, pipeline and beat count
      tag = 5;
      do_reset();
      for (int k = 1; k <= 3; k++) step(4'b0011, 4'b0000, c_ns, 1'b1, 0, 1'b0);
      for (int s = 0; s < 5; s++) step((s % 2) ? 4'b0111 : 4'b0011, 4'b0000, c_ns, 1'b0, 0, 1'b0);
      for (int k = 4; k <= 7; k++) step(4'b0011, 4'b0000, c_ns, 1'b1, 0, 1'b0);
      step(4'b0011, 4'b0000, c_ns, 1'b1, 1, 1'b0);
      repeat (3) step(4'b0100, 4'b0000, c_ns, 1'b0, 1, 1'b0);
      step(4'b0100, 4'b0000, c_ns, 1'b1, 2, 1'b0);

      // 6: reset mid-burst clears owner, lock and beat count
      tag = 6;
      do_reset();
      step(4'b1000, 4'b0000, c_ns, 1'b1, 3, 1'b0);
      for (int k = 2; k <= 6; k++) step(4'b1000, 4'b1000, c_ns, 1'b1, 3, 1'b0);
      do_reset();
      for (int k = 1; k <= 7; k++) step(4'b1001, 4'b0000, c_ns, 1'b1, 0, 1'b0);
      step(4'b1001, 4'b0000, c_ns, 1'b1, 3, 1'b0);
      step(4'b1001, 4'b0000, c_ns, 1'b1, 3, 1'b0);

      @(posedge clk);
      #3;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
